// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: 1-cycle latency, full throughput via a 2-entry skid buffer, in_ready registered
// (no combinational out_ready->in_ready path); sync flush empties it to NOP. Optional counters: PIPE_STAT_EN.
module pipe_stage_elastic #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(16'hF000)
`ifdef PIPE_STAT_EN
   ,
   parameter int               CNT_WIDTH = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
`ifdef PIPE_STAT_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] bubble_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             in_ready_q;
   logic             acc;
   logic             take;

   assign acc       = in_valid & in_ready_q;
   assign take      = out_valid & out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         // Anything taken this cycle is already delivered; the rest is dropped.
         state_nxt = EMPTY;
         main_nxt  = NOP_VALUE;
         skid_nxt  = NOP_VALUE;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (acc && take) begin
                  main_nxt = in_data;
               end else if (acc) begin
                  state_nxt = TWO;
                  skid_nxt  = in_data;
               end else if (take) begin
                  state_nxt = EMPTY;
                  main_nxt  = NOP_VALUE;
               end
            end
            TWO: begin
               if (take) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
                  skid_nxt  = NOP_VALUE;
               end
            end
            default: begin
               state_nxt = EMPTY;
               main_nxt  = NOP_VALUE;
               skid_nxt  = NOP_VALUE;
            end
         endcase
      end
   end

   // in_ready is a flop fed from next state, so it never sees out_ready combinationally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= EMPTY;
         main_q     <= NOP_VALUE;
         skid_q     <= NOP_VALUE;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         main_q     <= main_nxt;
         skid_q     <= skid_nxt;
         in_ready_q <= (state_nxt != TWO);
      end
   end

`ifdef PIPE_STAT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (in_valid && !in_ready_q && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
         if (out_ready && !out_valid && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + 1'b1;
         if (flush && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: reset, streaming, backpressure, flush, simultaneous acc/take, counters.
module tb_pipe_stage_elastic;

   localparam logic [15:0] NOP = 16'hF000;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'hDEAD;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [1:0]  occupancy;
`ifdef PIPE_STAT_EN
   logic [3:0]  stall_cnt, bubble_cnt, flush_cnt;
   int          m_stall = 0, m_bubble = 0, m_flush = 0;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          leak    = 0;
   logic [15:0] sb[$];
   logic [15:0] src[$];

   pipe_stage_elastic #(
      .WIDTH(16),
      .NOP_VALUE(16'hF000)
`ifdef PIPE_STAT_EN
      ,
      .CNT_WIDTH(4)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy)
`ifdef PIPE_STAT_EN
      ,
      .stall_cnt(stall_cnt),
      .bubble_cnt(bubble_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; drives one cycle, checks against the model, returns at next posedge+1.
   task automatic run_cycle(input logic ordy, input logic fl);
      logic        iv, acc, take;
      logic [15:0] exp;
      int          sz;
      iv        = (src.size() != 0);
      in_valid  = iv;
      in_data   = iv ? src[0] : 16'hDEAD;
      out_ready = ordy;
      flush     = fl;
      #2;
      sz = sb.size();
      check("occupancy", 32'(occupancy), 32'(sz));
      check("in_ready", 32'(in_ready), 32'(sz != 2));
      check("out_valid", 32'(out_valid), 32'(sz != 0));
      if (sz == 0) check("empty_nop", 32'(out_data), 32'(NOP));
`ifdef PIPE_STAT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (iv && sz == 2 && m_stall < 15) m_stall++;
      if (ordy && sz == 0 && m_bubble < 15) m_bubble++;
      if (fl && m_flush < 15) m_flush++;
`endif
      take = (sz != 0) && ordy;
      acc  = iv && (sz != 2);
      if (take) begin
         exp = sb.pop_front();
         check("out_data", 32'(out_data), 32'(exp));
         if (out_data inside {16'h00B1, 16'h00B2, 16'h00B3}) leak++;
      end
      if (acc) void'(src.pop_front());
      if (fl) sb.delete();
      else if (acc) sb.push_back(in_data);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'(NOP));
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_occupancy", 32'(occupancy), 32'd0);
`ifdef PIPE_STAT_EN
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
      sb.delete();
      src.delete();
      in_valid  = 1'b0;
      in_data   = 16'hDEAD;
      out_ready = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      do_reset();

      // Streaming 0x0001..0x0010 with out_ready held high.
      for (int i = 1; i <= 16; i++) src.push_back(16'(i));
      for (int i = 0; i < 18; i++) run_cycle(1'b1, 1'b0);
      check("stream_drained", 32'(sb.size() + src.size()), 32'd0);

      // Backpressure: two accepted, third held upstream, then release in order.
      src.push_back(16'h00A1); src.push_back(16'h00A2); src.push_back(16'h00A3);
      for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);
      check("bp_held", 32'(src.size()), 32'd1);
      for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0);
      check("bp_drained", 32'(sb.size() + src.size()), 32'd0);

      // Flush with two held and a third offered.
      src.push_back(16'h00B1); src.push_back(16'h00B2);
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b0);
      src.push_back(16'h00B3);
      run_cycle(1'b0, 1'b1);
      src.delete();
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
      check("flush_leak", 32'(leak), 32'd0);

      // Simultaneous accept/take at occupancy 1, then a take during flush.
      src.push_back(16'h00D1);
      run_cycle(1'b1, 1'b0);
      src.push_back(16'h00D2);
      run_cycle(1'b1, 1'b0);
      check("simul_head", 32'(out_data), 32'h00D2);
      src.push_back(16'h00C2);
      run_cycle(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
      check("flush_take_gone", 32'(out_valid), 32'd0);

      // Reset mid-stream with occupancy 2.
      src.push_back(16'h00E1); src.push_back(16'h00E2); src.push_back(16'h00E3);
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b0);
      check("pre_reset_occ", 32'(occupancy), 32'd2);
      do_reset();
      run_cycle(1'b1, 1'b0);

`ifdef PIPE_STAT_EN
      do_reset();
      for (int i = 0; i < 25; i++) src.push_back(16'h0100 + 16'(i));
      for (int i = 0; i < 22; i++) run_cycle(1'b0, 1'b0);
      check("stall_saturated", 32'(stall_cnt), 32'hF);
      src.delete();
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
      check("flush_count", 32'(flush_cnt), 32'd3);
      run_cycle(1'b1, 1'b0);
      do_reset();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
